// File: rtl/game_sequencer.sv
// Frame-synchronous game controller: IDLE/PLAY/OVER state machine, obstacle scrolling,
// LFSR-driven gap height, collision latch and saturating score.
module game_sequencer #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned H_START    = 1720,
  parameter int unsigned V_GAP_INIT = 400,
  parameter int unsigned GAP_MIN    = 100,
  parameter int unsigned SPEED      = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk_148_mhz,
  input  logic        rst_n,
  input  logic [11:0] h_count,
  input  logic [10:0] v_count,
  input  logic        display_on,
  input  logic        btn_start,
  input  logic        player_px,
  input  logic        obstacle_px,
  output logic [11:0] h_obstacle,
  output logic [10:0] v_gap,
  output logic [1:0]  game_state,
  output logic [7:0]  score,
  output logic        frame_tick
);

  // Obstacle must start on screen, and the tallest gap (GAP_MIN + 510 + 400) must fit.
  if (H_START >= H_ACTIVE || LFSR_SEED == 8'h00 || GAP_MIN + 910 > V_ACTIVE) begin : g_bad_param
    $error("game_sequencer: illegal parameter combination");
  end

  localparam logic [11:0] HStart   = 12'(H_START);
  localparam logic [11:0] SpeedW   = 12'(SPEED);
  localparam logic [10:0] VGapInit = 11'(V_GAP_INIT);
  localparam logic [10:0] GapMin   = 11'(GAP_MIN);
  localparam logic [10:0] VActive  = 11'(V_ACTIVE);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StOver = 2'b10,
    StBad  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] h_obs_q, h_obs_d;
  logic [10:0] v_gap_q, v_gap_d;
  logic [7:0]  score_q, score_d;
  logic        hit_q, hit_d;
  logic [7:0]  lfsr_q;
  logic        btn_meta_q, btn_sync_q, btn_prev_q;
  logic        frame_tick_q;
  logic        start_pulse;
  logic        lfsr_fb;

  assign start_pulse = btn_sync_q & ~btn_prev_q;
  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk_148_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      h_obs_q      <= HStart;
      v_gap_q      <= VGapInit;
      score_q      <= 8'd0;
      hit_q        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_prev_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_obs_q      <= h_obs_d;
      v_gap_q      <= v_gap_d;
      score_q      <= score_d;
      hit_q        <= hit_d;
      lfsr_q       <= {lfsr_q[6:0], lfsr_fb};
      btn_meta_q   <= btn_start;
      btn_sync_q   <= btn_meta_q;
      btn_prev_q   <= btn_sync_q;
      frame_tick_q <= (h_count == 12'd0) && (v_count == VActive);
    end
  end

  always_comb begin
    state_d = state_q;
    h_obs_d = h_obs_q;
    v_gap_d = v_gap_q;
    score_d = score_q;
    hit_d   = hit_q;

    // Clear has priority; the tick lands in blanking so it never races a real hit.
    if (frame_tick_q) begin
      hit_d = 1'b0;
    end else if (state_q == StPlay && display_on && player_px && obstacle_px) begin
      hit_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        h_obs_d = HStart;
        v_gap_d = VGapInit;
        score_d = 8'd0;
        if (start_pulse) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (frame_tick_q) begin
          if (hit_q) begin
            state_d = StOver;
          end else if (h_obs_q >= SpeedW) begin
            h_obs_d = h_obs_q - SpeedW;
          end else begin
            h_obs_d = HStart;
            v_gap_d = GapMin + {2'b00, lfsr_q, 1'b0};
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end
        end
      end
      StOver: begin
        if (start_pulse) begin
          state_d = StIdle;
          h_obs_d = HStart;
          v_gap_d = VGapInit;
          score_d = 8'd0;
          hit_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        h_obs_d = HStart;
        v_gap_d = VGapInit;
        score_d = 8'd0;
        hit_d   = 1'b0;
      end
    endcase
  end

  assign h_obstacle = h_obs_q;
  assign v_gap      = v_gap_q;
  assign game_state = state_q;
  assign score      = score_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer using a shortened 16-cycle frame and an LFSR reference.
module tb_game_sequencer;

  logic        clk_148_mhz = 1'b0;
  logic        rst_n       = 1'b0;
  logic [11:0] h_count;
  logic [10:0] v_count;
  logic        display_on;
  logic        btn_start   = 1'b0;
  logic        player_px   = 1'b0;
  logic        obstacle_px = 1'b0;
  logic [11:0] h_obstacle;
  logic [10:0] v_gap;
  logic [1:0]  game_state;
  logic [7:0]  score;
  logic        frame_tick;

  int          n_cmp = 0;
  int          n_err = 0;
  int          p     = 0;
  logic [7:0]  lfsr_m    = 8'hA5;
  logic [7:0]  lfsr_prev = 8'hA5;

  game_sequencer dut (
    .clk_148_mhz (clk_148_mhz),
    .rst_n       (rst_n),
    .h_count     (h_count),
    .v_count     (v_count),
    .display_on  (display_on),
    .btn_start   (btn_start),
    .player_px   (player_px),
    .obstacle_px (obstacle_px),
    .h_obstacle  (h_obstacle),
    .v_gap       (v_gap),
    .game_state  (game_state),
    .score       (score),
    .frame_tick  (frame_tick)
  );

  always #5 clk_148_mhz = ~clk_148_mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tiny frame: tick position at p==0 (blanking), active video for p>=8.
  task automatic drive();
    h_count    = 12'(p);
    v_count    = (p < 8) ? 11'd1080 : 11'd0;
    display_on = (p >= 8);
  endtask

  task automatic step();
    lfsr_prev = lfsr_m;
    @(posedge clk_148_mhz);
    if (rst_n) lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    #1;
    p = (p + 1) % 16;
    drive();
  endtask

  // Advance until a tick is seen, then past the edge that consumes it.
  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      int g;
      g = 0;
      while (!frame_tick && g < 64) begin
        step();
        g++;
      end
      if (g >= 64) check("tick_timeout", 32'd0, 32'd1);
      step();
    end
  endtask

  initial begin
    int n_pulse;
    int n_wide;
    logic last;
    drive();
    #22 rst_n = 1'b1;

    check("rst_state", game_state, 0);
    check("rst_h", h_obstacle, 1720);
    check("rst_v", v_gap, 400);
    check("rst_score", score, 0);
    check("rst_tick", frame_tick, 0);

    n_pulse = 0;
    n_wide  = 0;
    last    = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (frame_tick) n_pulse++;
      if (frame_tick && last) n_wide++;
      last = frame_tick;
    end
    check("tick_count", n_pulse, 3);
    check("tick_width", n_wide, 0);
    check("idle_state", game_state, 0);
    check("idle_h", h_obstacle, 1720);
    check("idle_v", v_gap, 400);
    check("idle_score", score, 0);

    // Collision pixels in IDLE must neither end the game nor carry into PLAY.
    player_px   = 1'b1;
    obstacle_px = 1'b1;
    run_frames(1);
    check("idle_px_no_over", game_state, 0);
    btn_start = 1'b1;
    step();
    step();
    check("start_lat2", game_state, 0);
    step();
    check("start_lat3", game_state, 1);
    player_px   = 1'b0;
    obstacle_px = 1'b0;
    repeat (7) step();
    btn_start = 1'b0;
    check("hold_single", game_state, 1);
    run_frames(5);
    check("play_state", game_state, 1);
    check("play_h5", h_obstacle, 1700);
    check("play_score0", score, 0);

    // Overlap during blanking is ignored.
    player_px   = 1'b1;
    obstacle_px = 1'b1;
    repeat (4) step();
    player_px   = 1'b0;
    obstacle_px = 1'b0;
    run_frames(1);
    check("blank_no_over", game_state, 1);
    check("blank_h", h_obstacle, 1696);

    for (int w = 1; w <= 7; w++) begin
      int g;
      g = 0;
      while (h_obstacle != 0 && g < 500) begin
        run_frames(1);
        g++;
      end
      check("reach_zero", h_obstacle, 0);
      run_frames(1);
      check("wrap_h", h_obstacle, 1720);
      check("wrap_score", score, w);
      check("wrap_vgap", v_gap, 100 + 2 * lfsr_prev);
      check("vgap_range", (v_gap >= 100 && v_gap <= 610), 1);
    end
    check("pre_rst_state", game_state, 1);

    // Asynchronous reset mid-line, checked before the next edge.
    step();
    step();
    #3 rst_n = 1'b0;
    lfsr_m = 8'hA5;
    #1;
    check("arst_state", game_state, 0);
    check("arst_score", score, 0);
    check("arst_h", h_obstacle, 1720);
    check("arst_v", v_gap, 400);
    check("arst_tick", frame_tick, 0);
    step();
    rst_n = 1'b1;

    btn_start = 1'b1;
    repeat (4) step();
    btn_start = 1'b0;
    check("restart_play", game_state, 1);
    run_frames(1);
    check("restart_h", h_obstacle, 1716);
    begin
      int g;
      g = 0;
      while (!display_on && g < 32) begin
        step();
        g++;
      end
    end
    player_px   = 1'b1;
    obstacle_px = 1'b1;
    step();
    player_px   = 1'b0;
    obstacle_px = 1'b0;
    run_frames(1);
    check("hit_over", game_state, 2);
    check("hit_h_frozen", h_obstacle, 1716);
    check("hit_score_frozen", score, 0);
    run_frames(2);
    check("over_state_held", game_state, 2);
    check("over_h_held", h_obstacle, 1716);
    btn_start = 1'b1;
    repeat (5) step();
    btn_start = 1'b0;
    step();
    check("over_to_idle", game_state, 0);
    check("over_idle_h", h_obstacle, 1720);
    check("over_idle_v", v_gap, 400);
    check("over_idle_score", score, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
